pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_skid_buf.sv | 111 +++++++++++
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage register:
//   - default payload and counter widths
//   - occupancy state encoding (EMPTY / FULL / SKID)
// The SKID state is only reachable when PIPE_STAGE_REG_SKID_EN is defined.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing presented
    FULL  = 2'd1,  // output entry presented
    SKID  = 2'd2   // output entry presented, second entry parked in skid
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Two-entry (output + skid) elastic buffer with a fully registered o_ready.
// o_ready has no combinational path from i_ready: a transfer arriving while
// the output entry is stalled is parked in the skid entry, and o_ready drops
// on the following cycle.
//
// Ports
//   i_clk, i_reset_n        clock, async active-low reset
//   i_flush                 sync flush, empties both entries
//   i_valid/o_ready/i_data/i_ctrl   upstream handshake + payload
//   o_valid/i_ready/o_data/o_ctrl   downstream handshake + payload
// o_ctrl is zero whenever o_valid is low; o_data holds its last value.
// ---------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  pipe_state_e       r_state;
  logic              r_ready;
  logic [DATA_W-1:0] r_out_data;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic w_in;
  logic w_out;
  logic w_valid;

  assign w_valid = (r_state != EMPTY);
  assign w_in    = i_valid && r_ready;
  assign w_out   = w_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= EMPTY;
      r_ready     <= 1'b1;
      r_out_data  <= '0;
      r_out_ctrl  <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (i_flush) begin
      // Flush beats any simultaneous transfer; o_data keeps its last value.
      r_state     <= EMPTY;
      r_ready     <= 1'b1;
      r_out_ctrl  <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in) begin
            r_out_data <= i_data;
            r_out_ctrl <= i_ctrl;
            r_state    <= FULL;
          end
        end
        FULL: begin
          if (w_in && w_out) begin
            r_out_data <= i_data;
            r_out_ctrl <= i_ctrl;
          end else if (w_in) begin
            // Output stalled: park the new entry and close the input.
            r_skid_data <= i_data;
            r_skid_ctrl <= i_ctrl;
            r_ready     <= 1'b0;
            r_state     <= SKID;
          end else if (w_out) begin
            r_out_ctrl <= '0;
            r_state    <= EMPTY;
          end
        end
        SKID: begin
          // r_ready is low here, so no new entry can arrive.
          if (w_out) begin
            r_out_data  <= r_skid_data;
            r_out_ctrl  <= r_skid_ctrl;
            r_skid_ctrl <= '0;
            r_ready     <= 1'b1;
            r_state     <= FULL;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = w_valid;
  assign o_data  = r_out_data;
  assign o_ctrl  = r_out_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage register with flush and a saturating stall
// counter. Latency 1, full throughput.
//
// Configuration macro: PIPE_STAGE_REG_SKID_EN
//   undefined : single entry, o_ready = !o_valid || i_ready (combinational)
//   defined   : pipe_skid_buf (two entries), o_ready registered
//
// Ports
//   i_clk, i_reset_n        clock, async active-low reset
//   i_flush                 sync flush of all held entries
//   i_valid/o_ready/i_data/i_ctrl   upstream handshake + payload
//   o_valid/i_ready/o_data/o_ctrl   downstream handshake + payload
//   i_cnt_clr               sync clear of stall counter (wins over increment)
//   o_stall_cnt             saturating count of cycles o_valid && !i_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [CTRL_W-1:0] w_ctrl;

`ifdef PIPE_STAGE_REG_SKID_EN

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_flush   (i_flush),
    .i_valid   (i_valid),
    .o_ready   (w_ready),
    .i_data    (i_data),
    .i_ctrl    (i_ctrl),
    .o_valid   (w_valid),
    .i_ready   (i_ready),
    .o_data    (w_data),
    .o_ctrl    (w_ctrl)
  );

`else

  pipe_state_e       r_state;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic              w_in;
  logic              w_out;

  assign w_valid = (r_state == FULL);
  // The entry can be replaced in the same cycle it leaves.
  assign w_ready = !w_valid || i_ready;
  assign w_in    = i_valid && w_ready;
  assign w_out   = w_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_flush) begin
      r_state <= EMPTY;
      r_ctrl  <= '0;
    end else if (w_in) begin
      r_state <= FULL;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end else if (w_out) begin
      // Bubble: control zeroed, data held.
      r_state <= EMPTY;
      r_ctrl  <= '0;
    end
  end

  assign w_data = r_data;
  assign w_ctrl = r_ctrl;

`endif

  // Stall counter: independent of flush.
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_valid && !i_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_ready     = w_ready;
  assign o_valid     = w_valid;
  assign o_data      = w_data;
  assign o_ctrl      = w_ctrl;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_ctrl;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic          i_cnt_clr;
  logic [NW-1:0] o_stall_cnt;

  always #5 i_clk = ~i_clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_ctrl      (i_ctrl),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_ctrl      (o_ctrl),
    .i_cnt_clr   (i_cnt_clr),
    .o_stall_cnt (o_stall_cnt)
  );

  // Reference model: FIFO of accepted entries, head is what is presented.
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q[$];
  int   m_cnt;
  bit   m_in;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic bit m_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || i_ready;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_in  = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("o_valid", 64'(o_valid), 64'(q.size() > 0));
    chk("o_ctrl", 64'(o_ctrl), (q.size() > 0) ? 64'(q[0].c) : 64'd0);
    if (q.size() > 0) chk("o_data", 64'(o_data), 64'(q[0].d));
    chk("o_ready", 64'(o_ready), 64'(m_ready()));
    chk("o_stall_cnt", 64'(o_stall_cnt), 64'(m_cnt));
  endtask

  // Check settled outputs, take one clock edge, advance the model.
  task automatic cycle();
    bit   vin, vout, stall;
    ent_t e;
    #2;
    check_all();
    @(posedge i_clk);
    if (!i_reset_n) begin
      model_reset();
    end else begin
      vin   = i_valid && m_ready();
      vout  = (q.size() > 0) && i_ready;
      stall = (q.size() > 0) && !i_ready;
      m_in  = vin && !i_flush;
      if (i_cnt_clr) m_cnt = 0;
      else if (stall && m_cnt < CNT_MAX) m_cnt++;
      if (i_flush) q.delete();
      else begin
        if (vout) q.delete(0);
        if (vin) begin
          e.d = i_data;
          e.c = i_ctrl;
          q.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_flush   = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b0;
    i_data    = '0;
    i_ctrl    = '0;
    i_cnt_clr = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_ctrl", 64'(o_ctrl), 64'd0);
    chk("rst_cnt", 64'(o_stall_cnt), 64'd0);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst_ready", 64'(o_ready), 64'd1);

    // Streaming 1..8
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      i_valid = 1'b1;
      i_data  = DW'(i);
      i_ctrl  = CW'(i);
      cycle();
    end
    i_valid = 1'b0;
    cycle();
    cycle();
    chk("stream_bubble_valid", 64'(o_valid), 64'd0);
    chk("stream_hold_data", 64'(o_data), 64'd8);
    chk("stream_cnt", 64'(o_stall_cnt), 64'd0);

    // Backpressure: A5 held, 5A offered behind it
    i_cnt_clr = 1'b1;
    cycle();
    i_cnt_clr = 1'b0;
    i_valid = 1'b1; i_data = 32'hA5; i_ctrl = 8'h01;
    cycle();
    i_ready = 1'b0; i_data = 32'h5A; i_ctrl = 8'h02;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (m_in) i_valid = 1'b0;
    end
    chk("bp_data", 64'(o_data), 64'hA5);
    chk("bp_cnt", 64'(o_stall_cnt), 64'd5);
    i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (m_in) i_valid = 1'b0;
    end
    chk("bp_drained_valid", 64'(o_valid), 64'd0);
    chk("bp_last_data", 64'(o_data), 64'h5A);

    // Flush with held entry and a new entry offered
    i_valid = 1'b1; i_data = 32'h33; i_ctrl = 8'hFF;
    cycle();
    i_valid = 1'b0; i_ready = 1'b0;
    cycle();
    i_flush = 1'b1; i_valid = 1'b1; i_data = 32'h77; i_ctrl = 8'h11;
    cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_ctrl", 64'(o_ctrl), 64'd0);
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("flush_no_entry", 64'(o_valid), 64'd0);
    end
    // Flush discards an entry accepted in the same cycle
    i_flush = 1'b1; i_valid = 1'b1; i_data = 32'h99; i_ctrl = 8'h22;
    cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_same_cycle", 64'(o_valid), 64'd0);

    // Saturation
    i_cnt_clr = 1'b1;
    cycle();
    i_cnt_clr = 1'b0;
    i_valid = 1'b1; i_data = 32'hC0DE; i_ctrl = 8'h04;
    cycle();
    i_valid = 1'b0; i_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_cnt", 64'(o_stall_cnt), 64'd15);
    i_cnt_clr = 1'b1;
    cycle();
    i_cnt_clr = 1'b0;
    chk("clr_cnt", 64'(o_stall_cnt), 64'd0);
    i_ready = 1'b1;
    cycle();
    cycle();

    // Async reset mid-cycle while valid
    i_valid = 1'b1; i_data = 32'h12345678; i_ctrl = 8'h3C; i_ready = 1'b0;
    cycle();
    i_valid = 1'b0;
    cycle();
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_ctrl", 64'(o_ctrl), 64'd0);
    chk("arst_data", 64'(o_data), 64'd0);
    chk("arst_cnt", 64'(o_stall_cnt), 64'd0);
    model_reset();
    #2;
    i_reset_n = 1'b1;
    i_ready = 1'b1;
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      i_valid   = ($urandom_range(0, 3) != 0);
      i_ready   = ($urandom_range(0, 3) != 0);
      i_flush   = ($urandom_range(0, 31) == 0);
      i_cnt_clr = ($urandom_range(0, 31) == 0);
      i_data    = $urandom;
      i_ctrl    = CW'($urandom);
      cycle();
    end
    i_valid = 1'b0; i_flush = 1'b0; i_cnt_clr = 1'b0; i_ready = 1'b1;
    cycle();
    cycle();
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
